// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C bus scheduler slice.
//   - state_e        : scheduler FSM states
//   - SPEED_*        : speed mode codes understood by the SCL clock manager
//   - DEF_*_CYC      : default timing constants for a 10 MHz system clock
//   - clog2Min1()    : counter width helper that never returns zero
// ---------------------------------------------------------------------------
package i2c_pkg;

   // Scheduler FSM states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CFG     = 3'd1,
      ST_START   = 3'd2,
      ST_ACTIVE  = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

   // Speed mode codes as driven to the clock manager
   localparam logic [1:0] SPEED_STD   = 2'b00;
   localparam logic [1:0] SPEED_FAST  = 2'b01;
   localparam logic [1:0] SPEED_FASTP = 2'b10;
   localparam logic [1:0] SPEED_HS    = 2'b11;

   // Default timing at 10 MHz: settle time, 10 ms watchdog, 4.7 us bus-free
   localparam int DEF_SETTLE_CYC  = 4;
   localparam int DEF_TIMEOUT_CYC = 100000;
   localparam int DEF_BUF_CYC     = 47;

   // Width able to hold value-1, with a floor of one bit so that a
   // degenerate count of 1 still produces a legal vector
   function automatic int clog2Min1(input int value);
      int w;
      w = $clog2(value);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_rr_arbiter
// Combinational round-robin pick. The search starts at the requester just
// above the last granted one (ptr_i + 1) and wraps, so the last winner has
// the lowest priority.
// Ports:
//   req_i   : request vector
//   ptr_i   : index of the last granted requester
//   gnt_o   : one-hot winner (all zero when nothing requests)
//   idx_o   : binary index of the winner
//   valid_o : at least one request is present
// ---------------------------------------------------------------------------
module i2c_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   // Walk the NUM_REQ candidates in priority order and keep the first hit.
   // The modulo keeps the wrap correct for non power-of-two NUM_REQ.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] candIdx;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      candIdx = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand    = (int'(ptr_i) + i) % NUM_REQ;
         candIdx = IDX_W'(cand);
         if (!valid_o && req_i[candIdx]) begin
            valid_o        = 1'b1;
            idx_o          = candIdx;
            gnt_o[candIdx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_bus_scheduler.sv
// ---------------------------------------------------------------------------
// i2c_bus_scheduler
// Shares one I2C master datapath (clock manager + transaction engine) among
// NUM_REQ requesters. A round-robin winner has its speed/divider latched
// into the clock manager, the clock is given SETTLE_CYC cycles to settle,
// the engine is started, the transfer is supervised by a watchdog, and
// BUF_CYC bus-free cycles are enforced before the next grant.
// Ports:
//   i_sys_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_req/i_req_speed/i_req_div: per-requester request, speed, divider
//   i_err_clr                  : clears the sticky error flags
//   o_gnt                      : one-hot grant
//   o_cm_enable/speed/divider  : clock manager control
//   i_cm_timing_valid          : clock manager reports usable timing
//   o_xfer_start/i_xfer_done   : engine start pulse / completion pulse
//   o_xfer_abort               : engine abort pulse on watchdog expiry
//   o_busy                     : scheduler not idle
//   o_timeout_err/o_cfg_err    : sticky error flags
// ---------------------------------------------------------------------------
module i2c_bus_scheduler
   import i2c_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int BUF_CYC     = DEF_BUF_CYC
) (
   input  logic                    i_sys_clk,
   input  logic                    i_rst_n,
   input  logic [NUM_REQ-1:0]      i_req,
   input  logic [2*NUM_REQ-1:0]    i_req_speed,
   input  logic [16*NUM_REQ-1:0]   i_req_div,
   input  logic                    i_err_clr,
   output logic [NUM_REQ-1:0]      o_gnt,
   output logic                    o_cm_enable,
   output logic [1:0]              o_cm_speed_mode,
   output logic [15:0]             o_cm_divider,
   input  logic                    i_cm_timing_valid,
   output logic                    o_xfer_start,
   input  logic                    i_xfer_done,
   output logic                    o_xfer_abort,
   output logic                    o_busy,
   output logic                    o_timeout_err,
   output logic                    o_cfg_err
);

   localparam int IDX_W = clog2Min1(NUM_REQ);
   localparam int CNT_W = clog2Min1((SETTLE_CYC > BUF_CYC) ? SETTLE_CYC : BUF_CYC);
   localparam int WD_W  = clog2Min1(TIMEOUT_CYC);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] BUF_LOAD    = CNT_W'(BUF_CYC - 1);
   localparam logic [WD_W-1:0]  WD_LOAD     = WD_W'(TIMEOUT_CYC - 1);

   state_e               state_q,        state_d;
   logic [IDX_W-1:0]     ptr_q,          ptr_d;
   logic [IDX_W-1:0]     gntIdx_q,       gntIdx_d;
   logic [CNT_W-1:0]     cnt_q,          cnt_d;
   logic [WD_W-1:0]      wdog_q,         wdog_d;
   logic [NUM_REQ-1:0]   gnt_q,          gnt_d;
   logic                 cmEnable_q,     cmEnable_d;
   logic [1:0]           cmSpeed_q,      cmSpeed_d;
   logic [15:0]          cmDiv_q,        cmDiv_d;
   logic                 xferStart_q,    xferStart_d;
   logic                 xferAbort_q,    xferAbort_d;
   logic                 busy_q,         busy_d;
   logic                 timeoutErr_q,   timeoutErr_d;
   logic                 cfgErr_q,       cfgErr_d;

   logic [NUM_REQ-1:0]   arbGnt;
   logic [IDX_W-1:0]     arbIdx;
   logic                 arbValid;

   logic                 enterRelease;
   logic                 setTimeout;
   logic                 setCfg;

   i2c_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_i   (i_req),
      .ptr_i   (ptr_q),
      .gnt_o   (arbGnt),
      .idx_o   (arbIdx),
      .valid_o (arbValid)
   );

   // Next-state logic. Every output is computed one cycle ahead and
   // registered, so each output is a pure function of the new state.
   // The start/abort pulses default low so they last a single cycle.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      gntIdx_d     = gntIdx_q;
      cnt_d        = cnt_q;
      wdog_d       = wdog_q;
      gnt_d        = gnt_q;
      cmEnable_d   = cmEnable_q;
      cmSpeed_d    = cmSpeed_q;
      cmDiv_d      = cmDiv_q;
      xferStart_d  = 1'b0;
      xferAbort_d  = 1'b0;
      enterRelease = 1'b0;
      setTimeout   = 1'b0;
      setCfg       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arbValid) begin
               state_d    = ST_CFG;
               gnt_d      = arbGnt;
               gntIdx_d   = arbIdx;
               cmEnable_d = 1'b1;
               cmSpeed_d  = i_req_speed[{arbIdx, 1'b0} +: 2];
               cmDiv_d    = i_req_div[{arbIdx, 4'b0000} +: 16];
               cnt_d      = SETTLE_LOAD;
            end
         end

         ST_CFG: begin
            // Timing validity is only judged once the settle time is over
            if (cnt_q == '0) begin
               if (i_cm_timing_valid) begin
                  state_d     = ST_START;
                  xferStart_d = 1'b1;
               end else begin
                  setCfg       = 1'b1;
                  enterRelease = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_START: begin
            state_d = ST_ACTIVE;
            wdog_d  = WD_LOAD;
         end

         ST_ACTIVE: begin
            // Completion is checked first so a done pulse coinciding with
            // watchdog expiry is treated as a clean finish
            if (i_xfer_done) begin
               enterRelease = 1'b1;
            end else if (wdog_q == '0) begin
               xferAbort_d  = 1'b1;
               setTimeout   = 1'b1;
               enterRelease = 1'b1;
            end else begin
               wdog_d = wdog_q - WD_W'(1);
            end
         end

         ST_RELEASE: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Common release entry: drop the grant and clock, remember the winner
      // for the next round-robin search, start the bus-free timer
      if (enterRelease) begin
         state_d    = ST_RELEASE;
         gnt_d      = '0;
         cmEnable_d = 1'b0;
         ptr_d      = gntIdx_q;
         cnt_d      = BUF_LOAD;
      end
   end

   // Busy mirrors the registered state, so it is derived from the next state
   always_comb begin
      busy_d = (state_d != ST_IDLE);
   end

   // Sticky error flags: a clear request loses against a simultaneous set
   always_comb begin
      timeoutErr_d = timeoutErr_q;
      cfgErr_d     = cfgErr_q;
      if (i_err_clr) begin
         timeoutErr_d = 1'b0;
         cfgErr_d     = 1'b0;
      end
      if (setTimeout) begin
         timeoutErr_d = 1'b1;
      end
      if (setCfg) begin
         cfgErr_d = 1'b1;
      end
   end

   // State and output registers; reset forces everything back to idle with
   // no abort pulse, regardless of what the engine was doing
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         gntIdx_q     <= '0;
         cnt_q        <= '0;
         wdog_q       <= '0;
         gnt_q        <= '0;
         cmEnable_q   <= 1'b0;
         cmSpeed_q    <= SPEED_STD;
         cmDiv_q      <= '0;
         xferStart_q  <= 1'b0;
         xferAbort_q  <= 1'b0;
         busy_q       <= 1'b0;
         timeoutErr_q <= 1'b0;
         cfgErr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         gntIdx_q     <= gntIdx_d;
         cnt_q        <= cnt_d;
         wdog_q       <= wdog_d;
         gnt_q        <= gnt_d;
         cmEnable_q   <= cmEnable_d;
         cmSpeed_q    <= cmSpeed_d;
         cmDiv_q      <= cmDiv_d;
         xferStart_q  <= xferStart_d;
         xferAbort_q  <= xferAbort_d;
         busy_q       <= busy_d;
         timeoutErr_q <= timeoutErr_d;
         cfgErr_q     <= cfgErr_d;
      end
   end

   assign o_gnt           = gnt_q;
   assign o_cm_enable     = cmEnable_q;
   assign o_cm_speed_mode = cmSpeed_q;
   assign o_cm_divider    = cmDiv_q;
   assign o_xfer_start    = xferStart_q;
   assign o_xfer_abort    = xferAbort_q;
   assign o_busy          = busy_q;
   assign o_timeout_err   = timeoutErr_q;
   assign o_cfg_err       = cfgErr_q;

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_scheduler
// Self-checking bench for i2c_bus_scheduler (4 requesters, settle 4,
// watchdog 50, bus-free 47). Directed scenarios are followed by randomized
// transactions; expectations come from a small transaction-level model
// (last-granted pointer plus the two sticky flags).
// ---------------------------------------------------------------------------
module tb_i2c_bus_scheduler;

   localparam int N       = 4;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 50;
   localparam int BUFCYC  = 47;

   logic            i_sys_clk;
   logic            i_rst_n;
   logic [N-1:0]    i_req;
   logic [2*N-1:0]  i_req_speed;
   logic [16*N-1:0] i_req_div;
   logic            i_err_clr;
   logic [N-1:0]    o_gnt;
   logic            o_cm_enable;
   logic [1:0]      o_cm_speed_mode;
   logic [15:0]     o_cm_divider;
   logic            i_cm_timing_valid;
   logic            o_xfer_start;
   logic            i_xfer_done;
   logic            o_xfer_abort;
   logic            o_busy;
   logic            o_timeout_err;
   logic            o_cfg_err;

   logic [27:0]     allOuts;

   int checks;
   int failures;
   int ptrM;
   bit tErrM;
   bit cErrM;

   i2c_bus_scheduler #(
      .NUM_REQ     (N),
      .SETTLE_CYC  (SETTLE),
      .TIMEOUT_CYC (TIMEOUT),
      .BUF_CYC     (BUFCYC)
   ) dut (
      .i_sys_clk         (i_sys_clk),
      .i_rst_n           (i_rst_n),
      .i_req             (i_req),
      .i_req_speed       (i_req_speed),
      .i_req_div         (i_req_div),
      .i_err_clr         (i_err_clr),
      .o_gnt             (o_gnt),
      .o_cm_enable       (o_cm_enable),
      .o_cm_speed_mode   (o_cm_speed_mode),
      .o_cm_divider      (o_cm_divider),
      .i_cm_timing_valid (i_cm_timing_valid),
      .o_xfer_start      (o_xfer_start),
      .i_xfer_done       (i_xfer_done),
      .o_xfer_abort      (o_xfer_abort),
      .o_busy            (o_busy),
      .o_timeout_err     (o_timeout_err),
      .o_cfg_err         (o_cfg_err)
   );

   assign allOuts = {o_gnt, o_cm_enable, o_cm_speed_mode, o_cm_divider,
                     o_xfer_start, o_xfer_abort, o_busy, o_timeout_err, o_cfg_err};

   // 10 ns system clock
   initial i_sys_clk = 1'b0;
   always #5 i_sys_clk = ~i_sys_clk;

   // Advance one cycle; afterwards outputs of the new cycle are stable and
   // inputs driven now are sampled at the following edge
   task automatic tick();
      @(posedge i_sys_clk);
      #1;
   endtask

   // One comparison: counted, asserted, reported on mismatch
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first requester found searching upward from the
   // last winner plus one, wrapping around
   function automatic int pickWinner(input logic [N-1:0] req, input int ptr);
      for (int step = 1; step <= N; step++) begin
         if (req[(ptr + step) % N]) return (ptr + step) % N;
      end
      return -1;
   endfunction

   // One complete transaction, starting and ending in IDLE.
   //   tv        : timing valid reported by the clock manager
   //   doneDelay : cycles after the start cycle at which done is pulsed,
   //               0 means never (watchdog expiry)
   //   clrAtEnd  : pulse i_err_clr in the cycle that decides the outcome
   //   noise     : drop the request and pulse a stray done during CFG
   task automatic applyStimulus(input logic [N-1:0] req, input logic [2*N-1:0] spd,
                                input logic [16*N-1:0] div, input bit tv,
                                input int doneDelay, input bit clrAtEnd, input bit noise);
      int         win;
      int         relTicks;
      logic [N-1:0] expGnt;
      logic [1:0]   expSpd;
      logic [15:0]  expDiv;
      win    = pickWinner(req, ptrM);
      expGnt = N'(1) << win;
      expSpd = spd[2*win +: 2];
      expDiv = div[16*win +: 16];
      i_req             = req;
      i_req_speed       = spd;
      i_req_div         = div;
      i_cm_timing_valid = tv;
      tick();
      checkOutput("grant", o_gnt, expGnt);
      checkOutput("cmEnable", o_cm_enable, 1'b1);
      checkOutput("cmSpeed", o_cm_speed_mode, expSpd);
      checkOutput("cmDivider", o_cm_divider, expDiv);
      checkOutput("busyCfg", o_busy, 1'b1);
      if (noise) begin
         i_req       = '0;
         i_xfer_done = 1'b1;
      end
      for (int k = 1; k < SETTLE; k++) begin
         tick();
         i_xfer_done = 1'b0;
         checkOutput("noStartInCfg", o_xfer_start, 1'b0);
         checkOutput("gntHoldCfg", o_gnt, expGnt);
      end
      if (!tv) begin
         if (clrAtEnd) i_err_clr = 1'b1;
         tick();
         i_err_clr = 1'b0;
         if (clrAtEnd) tErrM = 1'b0;
         cErrM    = 1'b1;
         relTicks = 0;
         checkOutput("noStartCfgFail", o_xfer_start, 1'b0);
         checkOutput("gntDropCfgFail", o_gnt, '0);
         checkOutput("cmEnDropCfgFail", o_cm_enable, 1'b0);
      end else begin
         tick();
         checkOutput("startPulse", o_xfer_start, 1'b1);
         checkOutput("gntHoldStart", o_gnt, expGnt);
         if (doneDelay > 0) begin
            for (int k = 1; k <= doneDelay; k++) begin
               tick();
               if (k == 1) checkOutput("startOneCycle", o_xfer_start, 1'b0);
               checkOutput("noAbortActive", o_xfer_abort, 1'b0);
            end
            i_xfer_done = 1'b1;
            if (clrAtEnd) i_err_clr = 1'b1;
            tick();
            i_xfer_done = 1'b0;
            i_err_clr   = 1'b0;
            if (clrAtEnd) begin
               tErrM = 1'b0;
               cErrM = 1'b0;
            end
            checkOutput("noAbortOnDone", o_xfer_abort, 1'b0);
            relTicks = 0;
         end else begin
            for (int k = 1; k <= TIMEOUT; k++) begin
               tick();
               checkOutput("noAbortBeforeExpiry", o_xfer_abort, 1'b0);
            end
            checkOutput("gntHoldAtExpiry", o_gnt, expGnt);
            if (clrAtEnd) i_err_clr = 1'b1;
            tick();
            i_err_clr = 1'b0;
            if (clrAtEnd) cErrM = 1'b0;
            tErrM = 1'b1;
            checkOutput("abortPulse", o_xfer_abort, 1'b1);
            checkOutput("timeoutErrAtAbort", o_timeout_err, tErrM);
            tick();
            checkOutput("abortOneCycle", o_xfer_abort, 1'b0);
            relTicks = 1;
         end
         checkOutput("gntDropDone", o_gnt, '0);
         checkOutput("cmEnDropDone", o_cm_enable, 1'b0);
      end
      ptrM = win;
      checkOutput("timeoutErr", o_timeout_err, tErrM);
      checkOutput("cfgErr", o_cfg_err, cErrM);
      while (relTicks < BUFCYC - 1) begin
         tick();
         relTicks++;
      end
      checkOutput("busyLastRelease", o_busy, 1'b1);
      checkOutput("noGntInRelease", o_gnt, '0);
      tick();
      checkOutput("busyIdle", o_busy, 1'b0);
      checkOutput("cmSpeedHeld", o_cm_speed_mode, expSpd);
      checkOutput("cmDividerHeld", o_cm_divider, expDiv);
      i_req = '0;
   endtask

   initial begin
      logic [N-1:0]     rReq;
      logic [2*N-1:0]   rSpd;
      logic [16*N-1:0]  rDiv;
      int               rDelay;
      checks            = 0;
      failures          = 0;
      ptrM              = 0;
      tErrM             = 1'b0;
      cErrM             = 1'b0;
      i_rst_n           = 1'b0;
      i_req             = '0;
      i_req_speed       = '0;
      i_req_div         = '0;
      i_err_clr         = 1'b0;
      i_cm_timing_valid = 1'b0;
      i_xfer_done       = 1'b0;

      // Reset values
      repeat (3) tick();
      checkOutput("resetOutputs", allOuts, '0);
      i_rst_n = 1'b1;
      tick();
      checkOutput("idleAfterReset", allOuts, '0);

      // Single request, fast mode, default divider, done 20 cycles after start
      applyStimulus(4'b0001, 8'b0000_0001, '0, 1'b1, 20, 1'b0, 1'b0);

      // Round robin with all requests held
      for (int i = 0; i < 5; i++) begin
         rSpd = 8'($urandom);
         rDiv = {$urandom, $urandom};
         applyStimulus(4'b1111, rSpd, rDiv, 1'b1, 5 + i, 1'b0, 1'b0);
      end

      // Watchdog expiry, then the flag survives a clean transfer
      applyStimulus(4'b0010, 8'($urandom), {$urandom, $urandom}, 1'b1, 0, 1'b0, 1'b0);
      applyStimulus(4'b0100, 8'($urandom), {$urandom, $urandom}, 1'b1, 7, 1'b0, 1'b1);

      // Standalone clear
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      tErrM     = 1'b0;
      cErrM     = 1'b0;
      checkOutput("errClrTimeout", o_timeout_err, tErrM);
      checkOutput("errClrCfg", o_cfg_err, cErrM);

      // Configuration failure, then timeout with a clear in the setting cycle
      applyStimulus(4'b1000, 8'($urandom), {$urandom, $urandom}, 1'b0, 0, 1'b0, 1'b0);
      applyStimulus(4'b0001, 8'($urandom), {$urandom, $urandom}, 1'b1, 0, 1'b1, 1'b0);

      // Configuration failure with a clear in the setting cycle
      applyStimulus(4'b0110, 8'($urandom), {$urandom, $urandom}, 1'b0, 0, 1'b1, 1'b0);

      // Done on the watchdog-zero cycle, starting from clean flags
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      tErrM     = 1'b0;
      cErrM     = 1'b0;
      applyStimulus(4'b1001, 8'($urandom), {$urandom, $urandom}, 1'b1, TIMEOUT, 1'b0, 1'b0);

      // Randomized transactions
      for (int i = 0; i < 10; i++) begin
         rReq   = N'($urandom_range(1, 15));
         rSpd   = 8'($urandom);
         rDiv   = {$urandom, $urandom};
         rDelay = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
         applyStimulus(rReq, rSpd, rDiv, ($urandom_range(0, 5) != 0), rDelay,
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end

      // Leave the pointer on requester 3, then reset in the middle of ACTIVE
      applyStimulus(4'b1000, 8'($urandom), {$urandom, $urandom}, 1'b1, 3, 1'b0, 1'b0);
      i_req             = 4'b1000;
      i_cm_timing_valid = 1'b1;
      tick();
      checkOutput("gntBeforeMidReset", o_gnt, 4'b1000);
      i_req = '0;
      repeat (SETTLE) tick();
      checkOutput("startBeforeMidReset", o_xfer_start, 1'b1);
      repeat (5) tick();
      i_rst_n = 1'b0;
      #1;
      checkOutput("resetMidActive", allOuts, '0);
      repeat (2) tick();
      checkOutput("resetHeld", allOuts, '0);
      i_rst_n = 1'b1;
      ptrM    = 0;
      tErrM   = 1'b0;
      cErrM   = 1'b0;
      tick();
      applyStimulus(4'b0101, 8'($urandom), {$urandom, $urandom}, 1'b1, 4, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
